// File: rtl/gpio_serial_loader.sv
// Serial loader for a chain of GPIO control blocks: fetches one configuration word
// per block, shifts it out MSB first, then pulses serial_load. Option: GPIO_LOADER_CHAIN_RESET_EN.
module gpio_serial_loader #(
    parameter int NUM_IO  = 19,
    parameter int IO_BITS = 13,
    parameter int CLK_DIV = 2,
    localparam int AW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start,
    output logic [AW-1:0]      cfg_addr,
    output logic               cfg_rd,
    input  logic [IO_BITS-1:0] cfg_data,
    output logic               serial_clock,
    output logic               serial_load,
    output logic               serial_resetn,
    output logic               serial_data_out,
    output logic               busy,
    output logic               done
);

    localparam int BW = (IO_BITS > 1) ? $clog2(IO_BITS) : 1;
    // Wide enough for the longest timed phase (2*CLK_DIV cycles, CLK_DIV <= 15).
    localparam int DW = 5;

    typedef enum logic [2:0] {
        IDLE,
`ifdef GPIO_LOADER_CHAIN_RESET_EN
        CHAIN_RST,
`endif
        FETCH,
        LATCH,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        FINISH
    } state_t;

    state_t               state, state_n;
    logic [AW-1:0]        word_idx, word_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [IO_BITS-1:0]   shift_reg, shift_n;
    logic [DW-1:0]        div_cnt;
    logic                 half_done;

    assign half_done = (div_cnt == DW'(CLK_DIV - 1));

    always_comb begin
        state_n = state;
        word_n  = word_idx;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef GPIO_LOADER_CHAIN_RESET_EN
                    state_n = CHAIN_RST;
`else
                    state_n = FETCH;
`endif
                    word_n = AW'(NUM_IO - 1);
                end
            end
`ifdef GPIO_LOADER_CHAIN_RESET_EN
            CHAIN_RST: if (div_cnt == DW'(2 * CLK_DIV - 1)) state_n = FETCH;
`endif
            FETCH: state_n = LATCH;
            LATCH: begin
                state_n = SHIFT_LO;
                shift_n = cfg_data;
                bit_n   = BW'(IO_BITS - 1);
            end
            SHIFT_LO: if (half_done) state_n = SHIFT_HI;
            SHIFT_HI: begin
                if (half_done) begin
                    if (bit_cnt != '0) begin
                        state_n = SHIFT_LO;
                        bit_n   = bit_cnt - 1'b1;
                        shift_n = shift_reg << 1;
                    end else if (word_idx != '0) begin
                        state_n = FETCH;
                        word_n  = word_idx - 1'b1;
                    end else begin
                        state_n = LOAD;
                    end
                end
            end
            LOAD:    if (half_done) state_n = FINISH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            word_idx  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            div_cnt   <= '0;
        end else begin
            state     <= state_n;
            word_idx  <= word_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
            div_cnt   <= (state_n != state || state == IDLE) ? '0 : div_cnt + 1'b1;
        end
    end

    // NOTE: outputs are registered from the next-state values so they line up with
    // the state they describe instead of lagging it by a cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cfg_addr        <= '0;
            cfg_rd          <= 1'b0;
            serial_clock    <= 1'b0;
            serial_load     <= 1'b0;
            serial_data_out <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            cfg_addr        <= word_n;
            cfg_rd          <= (state_n == FETCH);
            serial_clock    <= (state_n == SHIFT_HI);
            serial_load     <= (state_n == LOAD);
            serial_data_out <= (state_n == SHIFT_LO || state_n == SHIFT_HI) ? shift_n[IO_BITS-1] : 1'b0;
            busy            <= (state_n != IDLE && state_n != FINISH);
            done            <= (state_n == FINISH);
        end
    end

`ifdef GPIO_LOADER_CHAIN_RESET_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) serial_resetn <= 1'b1;
        else          serial_resetn <= (state_n != CHAIN_RST);
    end
`else
    assign serial_resetn = 1'b1;
`endif

endmodule

// File: doc/gpio_serial_loader.md
GPIO_SERIAL_LOADER -- requirements
Module: gpio_serial_loader

Interface
REQ-001 The block SHALL have parameter NUM_IO, default 19, giving the number of GPIO control blocks in the serial chain.
REQ-002 The block SHALL have parameter IO_BITS, default 13, giving the configuration bits per GPIO control block.
REQ-003 The block SHALL have parameter CLK_DIV, default 2 (legal range 1..15), giving the serial_clock half-period in wb_clk_i cycles.
REQ-004 The block SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: a single-cycle request to load the whole chain.
REQ-007 The block SHALL have port cfg_addr, output, clog2(NUM_IO) bits: index of the configuration word requested.
REQ-008 The block SHALL have port cfg_rd, output, 1 bit: read strobe for cfg_addr.
REQ-009 The block SHALL have port cfg_data, input, IO_BITS bits: the configuration word, valid the cycle after cfg_rd.
REQ-010 The block SHALL have port serial_clock, output, 1 bit: the chain shift clock.
REQ-011 The block SHALL have port serial_load, output, 1 bit: the chain load strobe.
REQ-012 The block SHALL have port serial_resetn, output, 1 bit: the chain reset, active-low.
REQ-013 The block SHALL have port serial_data_out, output, 1 bit: chain serial data.
REQ-014 The block SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, CHAIN_RST, FETCH, LATCH, SHIFT_LO, SHIFT_HI, LOAD, FINISH.
REQ-017 In IDLE, start=1 SHALL move to CHAIN_RST (macro defined) or FETCH (macro undefined), set busy=1, and set the word index to NUM_IO-1.
REQ-018 In IDLE, start=0 SHALL leave the block in IDLE; start while busy=1 SHALL be ignored, with no queuing.
REQ-019 FETCH SHALL last 1 cycle and drive cfg_rd=1 with cfg_addr=word index; LATCH SHALL last 1 cycle, capture cfg_data into the shift register, and load the bit counter with IO_BITS-1.
REQ-020 Words SHALL be sent from index NUM_IO-1 down to 0 (farthest block first); within a word, MSB first.
REQ-021 SHIFT_LO SHALL hold serial_clock=0 with serial_data_out=current bit for CLK_DIV cycles.
REQ-022 SHIFT_HI SHALL hold serial_clock=1 with serial_data_out unchanged for CLK_DIV cycles.
REQ-023 At the end of SHIFT_HI: if bits remain, go to SHIFT_LO with the next bit; else if the word index > 0, decrement it and go to FETCH; else go to LOAD.
REQ-024 LOAD SHALL drive serial_load=1 and serial_clock=0 for CLK_DIV cycles, then go to FINISH.
REQ-025 FINISH SHALL last 1 cycle with done=1 and busy=0, then go to IDLE.
REQ-026 A full load SHALL take 1 + NUM_IO*(2 + 2*CLK_DIV*IO_BITS) + CLK_DIV cycles from the start cycle to the done cycle, plus 2*CLK_DIV cycles when the macro is defined.
REQ-027 serial_data_out SHALL be 0 in every state other than SHIFT_LO and SHIFT_HI.
REQ-028 serial_clock and serial_load SHALL never be high in the same cycle.
REQ-029 All outputs SHALL be registered.
REQ-030 The half-period counter SHALL be CLK_DIV-bit-safe and SHALL wrap to 0 at each state change.

Reset
REQ-031 On wb_rst_i=1, the block SHALL immediately and asynchronously go to IDLE, with serial_clock=0, serial_load=0, serial_resetn=1, serial_data_out=0, busy=0, done=0, cfg_rd=0, cfg_addr=0, and the shift register and counters cleared.
REQ-032 Reset asserted mid-load SHALL abort the load with no serial_load pulse; the next start SHALL restart from index NUM_IO-1.

Configuration
REQ-033 With macro GPIO_LOADER_CHAIN_RESET_EN defined, CHAIN_RST SHALL drive serial_resetn=0 for 2*CLK_DIV cycles before entering FETCH.
REQ-034 With GPIO_LOADER_CHAIN_RESET_EN undefined, the CHAIN_RST state SHALL be absent and serial_resetn SHALL be constant 1.

Verification
REQ-035 With NUM_IO=2, IO_BITS=13, CLK_DIV=2, macro off, cfg[1]=13'h1A5B, cfg[0]=13'h0001, and start pulsed -> the bench SHALL see 26 serial_clock rises carrying 1A5B then 0001, MSB first, one serial_load pulse 2 cycles wide, and done exactly 111 cycles after start.
REQ-036 With the same setup and the macro on -> serial_resetn SHALL be low for 4 cycles immediately after start, and done SHALL arrive at 115 cycles.
REQ-037 start pulsed again while busy=1 at cycle 30 -> the bench SHALL see no disturbance, a single done, and exactly 26 clock rises.
REQ-038 wb_rst_i asserted at cycle 50 of a load -> all outputs SHALL go to reset values in the same cycle and there SHALL be no serial_load pulse; a new start SHALL then produce a complete correct load.
REQ-039 With CLK_DIV=1, NUM_IO=1, cfg[0]=13'h1FFF -> serial_data_out SHALL stay 1 for all 13 bits, each serial_clock high phase SHALL be 1 cycle, and done SHALL arrive at 30 cycles.
REQ-040 Across all scenarios -> the bench SHALL check serial_clock&serial_load==0 every cycle and that serial_data_out is stable throughout every SHIFT_HI phase.
